// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Next-state controller for the control-state datapath. Holds the current
//   control state and picks its successor each cycle from the sequencing
//   type and the candidate addresses offered by the current state. Adds
//   memory-wait stalling with a timeout trap, halt at instruction
//   boundaries, illegal-target trapping and a retired-instruction counter.
//
// Ports
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   ty                : sequencing type 00 IB, 01 SB, 10 BC, 11 DB
//   ib_addr           : decoder dispatch address (first state of instruction)
//   sb_addr           : addressing-mode second-level dispatch address
//   db_addr           : direct next address
//   bc_addr_t/_f      : branch targets for z=1 / z=0
//   z                 : zero flag
//   mem_req, mem_ack  : memory handshake (see below)
//   halt_req          : request halt at the next IB boundary
//   state             : current control state (also the FSM debug view)
//   stall             : combinational mem_req & ~mem_ack & ~halted
//   halted            : state == HALT_STATE
//   instr_start       : one-cycle pulse, cycle after a taken IB dispatch
//   instr_count       : taken IB dispatches, wraps
//   illegal_err       : sticky, an illegal next address was trapped
//   bus_err           : sticky, a stall timeout was trapped
//
// Memory handshake: mem_req is the request (valid) raised by the current
// state, mem_ack is the completion (ready). A cycle with mem_req=1 and
// mem_ack=1 completes and advances; mem_req=1 with mem_ack=0 holds state.
// Both are ignored while halted.
module micro_sequencer #(
  parameter int                 STATE_W     = 5,
  parameter logic [STATE_W-1:0] RESET_STATE = 5'b00111,
  parameter logic [STATE_W-1:0] LAST_STATE  = 5'b10101,
  parameter logic [STATE_W-1:0] HALT_STATE  = 5'b11111,
  parameter int                 TIMEOUT     = 16,
  parameter int                 CNT_W       = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         ty,
  input  logic [STATE_W-1:0] ib_addr,
  input  logic [STATE_W-1:0] sb_addr,
  input  logic [STATE_W-1:0] db_addr,
  input  logic [STATE_W-1:0] bc_addr_t,
  input  logic [STATE_W-1:0] bc_addr_f,
  input  logic               z,
  input  logic               mem_req,
  input  logic               mem_ack,
  input  logic               halt_req,
  output logic [STATE_W-1:0] state,
  output logic               stall,
  output logic               halted,
  output logic               instr_start,
  output logic [CNT_W-1:0]   instr_count,
  output logic               illegal_err,
  output logic               bus_err
);

  localparam logic [1:0] TY_IB = 2'b00;
  localparam logic [1:0] TY_SB = 2'b01;
  localparam logic [1:0] TY_BC = 2'b10;
  localparam logic [1:0] TY_DB = 2'b11;

  localparam int            SC_W       = $clog2(TIMEOUT + 1);
  // Trap on the stall cycle that would bring the count to TIMEOUT.
  localparam logic [SC_W-1:0] TIMEOUT_M1 = SC_W'(TIMEOUT - 1);

  logic [SC_W-1:0]    stall_cnt;
  logic [STATE_W-1:0] nxt;

  always_comb begin
    nxt = db_addr;
    case (ty)
      TY_IB:   nxt = ib_addr;
      TY_SB:   nxt = sb_addr;
      TY_BC:   nxt = z ? bc_addr_t : bc_addr_f;
      TY_DB:   nxt = db_addr;
      default: nxt = db_addr;
    endcase
  end

  assign halted = (state == HALT_STATE);
  assign stall  = mem_req & ~mem_ack & ~halted;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RESET_STATE;
      instr_start <= 1'b0;
      instr_count <= '0;
      illegal_err <= 1'b0;
      bus_err     <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      instr_start <= 1'b0;
      if (halted) begin
        stall_cnt <= '0;
        // Resume straight into the held decoder address; counts as a dispatch.
        if (!halt_req) begin
          state       <= ib_addr;
          instr_count <= instr_count + CNT_W'(1);
          instr_start <= 1'b1;
        end
      end else if (stall) begin
        if (stall_cnt == TIMEOUT_M1) begin
          state     <= RESET_STATE;
          bus_err   <= 1'b1;
          stall_cnt <= '0;
        end else begin
          stall_cnt <= stall_cnt + SC_W'(1);
        end
      end else begin
        stall_cnt <= '0;
        if (ty == TY_IB && halt_req) begin
          state <= HALT_STATE;
        end else if (nxt > LAST_STATE) begin
          state       <= RESET_STATE;
          illegal_err <= 1'b1;
        end else begin
          state <= nxt;
          if (ty == TY_IB) begin
            instr_count <= instr_count + CNT_W'(1);
            instr_start <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

  localparam int W  = 25;   // {state, halted, illegal, bus, start, count}
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ty = 2'b11;
  logic [4:0]  ib_addr = '0, sb_addr = '0, db_addr = '0, bc_addr_t = '0, bc_addr_f = '0;
  logic        z = 1'b0, mem_req = 1'b0, mem_ack = 1'b0, halt_req = 1'b0;
  logic [4:0]  state;
  logic        stall, halted, instr_start, illegal_err, bus_err;
  logic [15:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  micro_sequencer dut (
    .clock(clock), .reset(reset), .ty(ty), .ib_addr(ib_addr), .sb_addr(sb_addr),
    .db_addr(db_addr), .bc_addr_t(bc_addr_t), .bc_addr_f(bc_addr_f), .z(z),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req), .state(state),
    .stall(stall), .halted(halted), .instr_start(instr_start),
    .instr_count(instr_count), .illegal_err(illegal_err), .bus_err(bus_err)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // Architectural view: where the machine is, how long it has been waiting
  // on memory, how many instructions have started, and the error flags.
  int          m_state = 7;
  int          m_wait  = 0;
  int          m_count = 0;
  bit          m_start = 0, m_ill = 0, m_bus = 0, m_valid = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clock) begin
    int  target, ns, nw, nc;
    bit  nstart, nill, nbus;
    ns = m_state; nw = 0; nc = m_count; nstart = 0; nill = m_ill; nbus = m_bus;
    case (ty)
      2'd0: target = ib_addr;
      2'd1: target = sb_addr;
      2'd2: target = z ? bc_addr_t : bc_addr_f;
      default: target = db_addr;
    endcase
    if (reset) begin
      ns = 7; nc = 0; nill = 0; nbus = 0;
    end else if (m_state == 31) begin
      if (!halt_req) begin ns = ib_addr; nc = (m_count + 1) % 65536; nstart = 1; end
    end else if (mem_req && !mem_ack) begin
      if (m_wait + 1 >= TO) begin ns = 7; nbus = 1; end
      else nw = m_wait + 1;
    end else if (ty == 2'd0 && halt_req) begin
      ns = 31;
    end else if (target > 21) begin
      ns = 7; nill = 1;
    end else begin
      ns = target;
      if (ty == 2'd0) begin nc = (m_count + 1) % 65536; nstart = 1; end
    end
    m_state <= ns; m_wait <= nw; m_count <= nc;
    m_start <= nstart; m_ill <= nill; m_bus <= nbus; m_valid <= 1;
    exp_q.push_back({5'(ns), ns == 31, nill, nbus, nstart, 16'(nc)});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    logic [W-1:0] e, a;
    bit exp_stall;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, halted, illegal_err, bus_err, instr_start, instr_count};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL model_outputs t=%0t actual=%h required=%h", $time, a, e);
      end
    end
    if (m_valid) begin
      exp_stall = mem_req && !mem_ack && (m_state != 31);
      n_cmp++;
      if (stall !== exp_stall) begin
        n_bad++;
        $display("FAIL model_stall t=%0t actual=%b required=%b", $time, stall, exp_stall);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [1:0] t, input logic [4:0] ib, input logic [4:0] sb,
                        input logic [4:0] db, input logic [4:0] bt, input logic [4:0] bf,
                        input logic zz, input logic mr, input logic ma, input logic hr);
    ty = t; ib_addr = ib; sb_addr = sb; db_addr = db; bc_addr_t = bt; bc_addr_f = bf;
    z = zz; mem_req = mr; mem_ack = ma; halt_req = hr;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(22, 31));
    return 5'($urandom_range(0, 21));
  endfunction

  initial begin
    int burst;
    // Reset, then a direct jump.
    set_in(2'b11, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0);
    reset = 1; cycle(); cycle();
    check("reset_state", state, 5'b00111);
    check("reset_count", instr_count, 0);
    check("reset_flags", {illegal_err, bus_err, instr_start, halted}, 0);
    reset = 0; cycle();
    check("db_jump", state, 5'b00001);
    check("db_count", instr_count, 0);

    // Branch on z.
    set_in(2'b10, 0, 0, 0, 5'b00110, 5'b00111, 1, 0, 0, 0); cycle();
    check("bc_taken", state, 5'b00110);
    z = 0; cycle();
    check("bc_not_taken", state, 5'b00111);

    // Three back-to-back IB dispatches.
    set_in(2'b00, 5'b01100, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("ib_start", instr_start, 1);
      check("ib_count", instr_count, i);
    end
    check("ib_state", state, 5'b01100);

    // Five wait cycles, then ack.
    set_in(2'b11, 0, 0, 5'b00010, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1 check("wait_stall", stall, 1);
      cycle();
      check("wait_hold", state, 5'b01100);
    end
    mem_ack = 1; #1 check("ack_no_stall", stall, 0);
    cycle();
    check("ack_advance", state, 5'b00010);
    check("ack_start_low", instr_start, 0);

    // Sixteen unacked cycles trap to fetch.
    mem_ack = 0;
    for (int i = 0; i < 15; i++) cycle();
    check("to_hold15", state, 5'b00010);
    check("to_no_err15", bus_err, 0);
    cycle();
    check("to_trap_state", state, 5'b00111);
    check("to_bus_err", bus_err, 1);

    // Illegal direct target.
    set_in(2'b11, 0, 0, 5'b10110, 0, 0, 0, 0, 0, 0); cycle();
    check("ill_state", state, 5'b00111);
    check("ill_flag", illegal_err, 1);
    db_addr = 5'b10101; cycle();
    check("last_legal", state, 5'b10101);
    check("ill_sticky", illegal_err, 1);

    // Halt at IB boundary, then resume.
    set_in(2'b00, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    check("halt_state", state, 5'b11111);
    check("halt_flag", halted, 1);
    check("halt_count", instr_count, 3);
    mem_req = 1; #1 check("halt_no_stall", stall, 0);
    cycle();
    check("halt_hold", state, 5'b11111);
    mem_req = 0; halt_req = 0; cycle();
    check("resume_state", state, 5'b01000);
    check("resume_count", instr_count, 4);
    check("resume_start", instr_start, 1);
    cycle();
    check("resume_start_pulse", instr_start, 1);  // still IB with ib_addr legal
    check("resume_count2", instr_count, 5);

    // Reset clears sticky flags.
    reset = 1; cycle(); reset = 0;
    check("rst_clear", {illegal_err, bus_err, instr_count}, 0);

    // Randomized run checked by the model.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      set_in(2'($urandom_range(0, 3)), rand_addr(), rand_addr(), rand_addr(), rand_addr(),
             rand_addr(), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
             1'($urandom_range(0, 1)), halt_req);
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(10, 20);
      if (burst > 0) begin mem_req = 1; mem_ack = 0; burst--; end
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 0;
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Next-state controller for the 5-bit control-state datapath: holds the current control state and computes its successor each cycle from the sequencing type (TY) and the candidate addresses the current state emits.
- Adds memory-wait stalling with a timeout, halt at instruction boundaries, illegal-target trapping and a retired-instruction counter.
- Sits between the instruction decoder / datapath state logic and the state register; drives the state that selects datapath micro-operations.

Parameters:
- STATE_W, 5, width of the control-state encoding
- RESET_STATE, 5'b00111, fetch state (brzz3) entered after reset or trap
- LAST_STATE, 5'b10101, highest legal datapath state (oprr2)
- HALT_STATE, 5'b11111, dedicated halt encoding
- TIMEOUT, 16, maximum consecutive stall cycles before bus-error trap
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ty  in  2  sequencing type: 00 IB, 01 SB, 10 BC, 11 DB
- ib_addr  in  STATE_W  decoder dispatch address (first state of instruction)
- sb_addr  in  STATE_W  addressing-mode second-level dispatch address
- db_addr  in  STATE_W  direct next address
- bc_addr_t  in  STATE_W  branch-condition target when z=1
- bc_addr_f  in  STATE_W  branch-condition target when z=0
- z  in  1  zero flag
- mem_req  in  1  current state performs a memory access
- mem_ack  in  1  memory completes access this cycle
- halt_req  in  1  request halt at next IB boundary
- state  out  STATE_W  current control state
- stall  out  1  combinational: mem_req & ~mem_ack & ~halted
- halted  out  1  state == HALT_STATE
- instr_start  out  1  registered one-cycle pulse: IB dispatch taken last cycle
- instr_count  out  CNT_W  number of IB dispatches taken, wraps
- illegal_err  out  1  sticky: illegal next address trapped
- bus_err  out  1  sticky: stall timeout trapped

Behaviour:
- Reset (synchronous, active-high): state=RESET_STATE, instr_start=0, instr_count=0, illegal_err=0, bus_err=0, internal stall counter=0. Reset overrides every other input.
- Candidate next address (nxt), selected by ty:
  - IB: ib_addr
  - SB: sb_addr
  - BC: z ? bc_addr_t : bc_addr_f
  - DB: db_addr
- Per-cycle priority, highest first:
  1. In HALT_STATE: hold while halt_req=1. On the cycle halt_req=0, go to ib_addr (the decoder holds it because ire is stable), count it as an IB dispatch and pulse instr_start. mem_req/mem_ack are ignored while halted.
  2. Stall (mem_req=1, mem_ack=0): hold state and increment the stall counter.
     - If the counter would reach TIMEOUT: next state = RESET_STATE, bus_err set, counter cleared.
  3. ty=IB and halt_req=1: next state = HALT_STATE. No dispatch is counted.
  4. Otherwise, if nxt > LAST_STATE: next state = RESET_STATE and illegal_err is set. HALT_STATE is never a legal nxt value.
  5. Otherwise: next state = nxt.
- The stall counter clears on any non-stall cycle. A mem_ack in the same cycle as mem_req advances normally, so access latency is zero.
- instr_count increments by 1 on every taken IB dispatch (case 5 with ty=IB, or halt resume) and wraps at 2^CNT_W−1 → 0.
- Latency: inputs are sampled at cycle N; state reflects the decision at N+1. instr_start is high for exactly cycle N+1 of a taken IB.
- Sticky error flags clear only on reset. Traps do not stop sequencing; execution restarts at fetch.
- Simultaneous events:
  - A stall suppresses the halt check. Halt is taken on the first non-stalled IB cycle.
  - Timeout takes precedence over an illegal nxt in the same cycle.
  - Reset mid-stall or mid-halt forces RESET_STATE on the next edge.

Test Plan:
- Reset then ty=DB with db_addr=00001 → state 00111 after reset, 00001 one cycle later; flags 0, instr_count=0.
- ty=BC, bc_addr_t=00110, bc_addr_f=00111, z=1 then z=0 → state 00110, then 00111.
- ty=IB, ib_addr=01100, three times back to back → instr_count=3, instr_start high for 3 cycles, state=01100.
- mem_req=1, mem_ack=0 for 5 cycles then ack → state held 5 cycles, stall=1, then advances to db_addr; with TIMEOUT=16 and 16 unacked cycles → state=00111, bus_err=1.
- ty=DB, db_addr=10110 → state=00111, illegal_err=1, stays 1 until reset.
- halt_req=1 at IB with ib_addr=01000 → state=11111, halted=1, count unchanged; drop halt_req → state=01000, instr_count +1, instr_start pulse.
